// File: rtl/pw_pkg.sv
// ----------------------------------------------------------------------------
// pw_pkg
// Shared definitions for the doorlock password path: the password register,
// the comparator and the nibble reader all use these.
//   DIGITS    : nibble slots in a password word
//   EMPTY_NIB : marker value of an unused slot
//   LEN_W     : width of a digit count (0..DIGITS)
//   pw_state_e: readout FSM states
// ----------------------------------------------------------------------------
package pw_pkg;

    localparam int         DIGITS    = 32;
    localparam logic [3:0] EMPTY_NIB = 4'hF;
    localparam int         LEN_W     = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } pw_state_e;

endpackage : pw_pkg

// File: rtl/pw_len_count.sv
// ----------------------------------------------------------------------------
// pw_len_count
// Combinational digit counter for a password word. Empty slots are packed at
// the most-significant end, so the stored length is DIGITS minus the length
// of the leading run of EMPTY_NIB nibbles. An EMPTY_NIB value below the first
// real digit is an ordinary digit and ends the run.
// Ports:
//   word : 4*DIGITS  password word, newest digit in bits [3:0]
//   len  : LEN_W     number of stored digits
// ----------------------------------------------------------------------------
module pw_len_count #(
    parameter int         DIGITS    = pw_pkg::DIGITS,
    parameter logic [3:0] EMPTY_NIB = pw_pkg::EMPTY_NIB,
    parameter int         LEN_W     = pw_pkg::LEN_W
) (
    input  logic [4*DIGITS-1:0] word,
    output logic [LEN_W-1:0]    len
);

    logic [LEN_W-1:0] lead_s;
    logic             stop_s;

    // Count the leading run of empty slots, scanning from the MSB nibble down.
    always_comb begin
        lead_s = '0;
        stop_s = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (!stop_s && (word[4*i +: 4] == EMPTY_NIB)) begin
                lead_s = lead_s + LEN_W'(1);
            end else begin
                stop_s = 1'b1;
            end
        end
        len = LEN_W'(DIGITS) - lead_s;
    end

endmodule : pw_len_count

// File: rtl/pw_nibble_reader.sv
// ----------------------------------------------------------------------------
// pw_nibble_reader
// Captures a stored password word on start and streams its digits out one
// nibble per transfer, oldest digit first, over a valid/ready handshake.
// Ports:
//   clk, rstn   : clock (rising edge), asynchronous active-low reset
//   clr         : synchronous abort back to IDLE (len is kept)
//   start       : readout request, honoured only in IDLE
//   pw_in       : password word, captured into a shadow register on start
//   dout        : current digit
//   dout_valid  : dout holds a digit
//   dout_ready  : consumer takes dout this cycle
//   dout_last   : dout is the final digit (qualified by dout_valid)
//   len         : digit count of the captured word, held until next start
//   busy        : high in SCAN, SEND and DONE
//   done        : one-cycle pulse when a readout completes
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module pw_nibble_reader
    import pw_pkg::pw_state_e;
    import pw_pkg::IDLE;
    import pw_pkg::SCAN;
    import pw_pkg::SEND;
    import pw_pkg::DONE;
#(
    parameter int         DIGITS    = pw_pkg::DIGITS,
    parameter logic [3:0] EMPTY_NIB = pw_pkg::EMPTY_NIB,
    parameter int         LEN_W     = pw_pkg::LEN_W
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                clr,
    input  logic                start,
    input  logic [4*DIGITS-1:0] pw_in,
    output logic [3:0]          dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                dout_last,
    output logic [LEN_W-1:0]    len,
    output logic                busy,
    output logic                done
);

    pw_state_e           state_r;
    pw_state_e           state_nxt_s;
    logic [4*DIGITS-1:0] shadow_r;
    logic [4*DIGITS-1:0] shadow_nxt_s;
    logic [LEN_W-1:0]    idx_r;
    logic [LEN_W-1:0]    idx_nxt_s;
    logic [3:0]          dout_nxt_s;
    logic                dout_valid_nxt_s;
    logic                dout_last_nxt_s;
    logic [LEN_W-1:0]    len_nxt_s;
    logic                done_nxt_s;
    logic [LEN_W-1:0]    scan_len_s;
    logic [LEN_W-1:0]    scan_idx_s;
    logic [LEN_W-1:0]    dec_idx_s;

    // Nibble slot 'idx' of a password word.
    function automatic logic [3:0] nib_at(input logic [4*DIGITS-1:0] w,
                                          input logic [LEN_W-1:0]    idx);
        return w[{idx, 2'b00} +: 4];
    endfunction

    pw_len_count #(
        .DIGITS    (DIGITS),
        .EMPTY_NIB (EMPTY_NIB),
        .LEN_W     (LEN_W)
    ) u_len_count (
        .word (shadow_r),
        .len  (scan_len_s)
    );

    assign scan_idx_s = scan_len_s - LEN_W'(1);
    assign dec_idx_s  = idx_r - LEN_W'(1);

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and next-output decode. dout_valid is computed from state
    // only, so it never follows dout_ready combinationally.
    always_comb begin
        state_nxt_s      = state_r;
        shadow_nxt_s     = shadow_r;
        idx_nxt_s        = idx_r;
        dout_nxt_s       = dout;
        dout_valid_nxt_s = dout_valid;
        dout_last_nxt_s  = dout_last;
        len_nxt_s        = len;
        done_nxt_s       = 1'b0;
        if (clr) begin
            state_nxt_s      = IDLE;
            dout_valid_nxt_s = 1'b0;
            dout_last_nxt_s  = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        shadow_nxt_s = pw_in;
                        state_nxt_s  = SCAN;
                    end else begin
                        state_nxt_s  = IDLE;
                    end
                end
                SCAN: begin
                    len_nxt_s = scan_len_s;
                    if (scan_len_s == '0) begin
                        state_nxt_s = DONE;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s      = SEND;
                        idx_nxt_s        = scan_idx_s;
                        dout_nxt_s       = nib_at(shadow_r, scan_idx_s);
                        dout_valid_nxt_s = 1'b1;
                        dout_last_nxt_s  = (scan_idx_s == '0);
                    end
                end
                SEND: begin
                    if (dout_valid && dout_ready) begin
                        if (idx_r == '0) begin
                            state_nxt_s      = DONE;
                            dout_valid_nxt_s = 1'b0;
                            dout_last_nxt_s  = 1'b0;
                            done_nxt_s       = 1'b1;
                        end else begin
                            idx_nxt_s       = dec_idx_s;
                            dout_nxt_s      = nib_at(shadow_r, dec_idx_s);
                            dout_last_nxt_s = (dec_idx_s == '0);
                        end
                    end else begin
                        state_nxt_s = SEND;
                    end
                end
                DONE: begin
                    state_nxt_s = IDLE;
                end
                default: begin
                    state_nxt_s      = IDLE;
                    dout_valid_nxt_s = 1'b0;
                    dout_last_nxt_s  = 1'b0;
                end
            endcase
        end
    end

    // Datapath and output registers; busy is registered from the next state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow_r   <= '1;
            idx_r      <= '0;
            dout       <= 4'h0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            len        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            shadow_r   <= shadow_nxt_s;
            idx_r      <= idx_nxt_s;
            dout       <= dout_nxt_s;
            dout_valid <= dout_valid_nxt_s;
            dout_last  <= dout_last_nxt_s;
            len        <= len_nxt_s;
            busy       <= (state_nxt_s != IDLE);
            done       <= done_nxt_s;
        end
    end

endmodule : pw_nibble_reader

// File: doc/pw_nibble_reader.md
# pw_nibble_reader

Reads back a stored password word produced by the doorlock password shift register and streams its digits out one 4-bit nibble at a time, oldest digit first, over a valid/ready handshake. Empty nibble slots hold 4'hF and occupy the most-significant end; the newest digit sits in bits [3:0]. The block feeds the comparator/display path and reports the stored digit count.

## Interface
Parameters:
- DIGITS, 32, nibble slots in the password word
- EMPTY_NIB, 4'hF, marker value of an unused slot
- LEN_W, $clog2(DIGITS+1) = 6, width of the digit count

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous abort; highest priority after rstn
- start  in  1  request a readout; sampled only in IDLE
- pw_in  in  4*DIGITS  stored password word; captured on accepted start
- dout  out  4  current digit
- dout_valid  out  1  dout holds a digit
- dout_ready  in  1  consumer accepts dout this cycle
- dout_last  out  1  dout is the final digit; qualified by dout_valid
- len  out  LEN_W  digit count of the captured word; held until next start
- busy  out  1  high in SCAN, SEND and DONE
- done  out  1  one-cycle pulse at end of readout

## Operation
- States: IDLE, SCAN, SEND, DONE.
- IDLE: start=1 captures pw_in into a shadow register, goes to SCAN. start outside IDLE is ignored.
- SCAN (1 cycle): len = DIGITS minus count of consecutive EMPTY_NIB nibbles from the MSB end. Index register idx = len-1. len=0 goes to DONE, else SEND.
- SEND: dout = shadow[4*idx +: 4], dout_valid=1, dout_last=(idx==0). Transfer when dout_valid && dout_ready: idx==0 goes to DONE, else idx decrements.
- DONE: done=1 for exactly one cycle, then IDLE.
- Interior 4'hF nibbles (below the first non-empty slot) are emitted as ordinary digits; only the leading run counts as empty.
- Full word (no leading F): len=DIGITS=32, idx starts at 31.
- clr in any state: next cycle IDLE, dout_valid=0, done not pulsed, len retains value; clr together with start in IDLE: clr wins, no capture.
- pw_in changes after capture have no effect on the current readout.

## Timing
- Reset values: dout=0, dout_valid=0, dout_last=0, len=0, busy=0, done=0, state IDLE, shadow all-ones.
- start sampled at edge N: SCAN during cycle N+1 (busy=1), len valid and first dout_valid at cycle N+2.
- One digit per cycle with dout_ready held high; len digits take len cycles in SEND.
- dout_ready low: dout, dout_last, dout_valid held stable; dout_valid never depends combinationally on dout_ready.
- Final transfer at edge M: done=1 during cycle M+1, busy drops at cycle M+2; start accepted again at edge M+2.
- Empty word: SCAN then DONE; done at cycle N+2, no dout_valid ever asserted.
- All outputs registered or decoded from registered state only.

## Structure
- Shared package pw_pkg: DIGITS, EMPTY_NIB, LEN_W, state enum (IDLE, SCAN, SEND, DONE); shared with the password register and comparator.
- One sub-module: pw_len_count, combinational leading-EMPTY_NIB counter, 4*DIGITS in, LEN_W out; reusable by the comparator.
- Top holds FSM, shadow register, idx counter, output registers.

## Test plan
- pw_in = 28 x F then nibbles 1,2,3,4, start pulse, dout_ready=1 -> len=4; dout 1,2,3,4 on consecutive cycles from N+2; dout_last only with 4; done one cycle later.
- Same word, dout_ready toggled 1,0,0,1 per cycle -> each digit held stable while ready low; sequence 1,2,3,4 unchanged; no digit dropped or duplicated.
- pw_in all F -> len=0, dout_valid never high, done at N+2.
- pw_in = 32 digits 0..9 repeating, no F at top -> len=32, 32 transfers, first digit from bits [127:124], last from [3:0].
- pw_in = 29 x F, 7, F, 5 -> len=3, output 7, F, 5 (interior F passed through).
- clr asserted after second transfer of the 1,2,3,4 case -> dout_valid low next cycle, no done pulse; second start while busy ignored; new start afterwards replays from the first digit.
